// File: rtl/cmos_spi_cmd_scheduler_pkg.sv
// Shared definitions for the CMOS sensor SPI command scheduler:
// FSM state encoding, delay-counter indices and command-word field helpers.
package cmos_spi_cmd_scheduler_pkg;

  // Scheduler FSM states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_POP       = 4'd1,
    ST_LOAD      = 4'd2,
    ST_START     = 4'd3,
    ST_WAIT_BUSY = 4'd4,
    ST_WAIT_IDLE = 4'd5,
    ST_GAP       = 4'd6,
    ST_SETTLE    = 4'd7,
    ST_FRAME     = 4'd8
  } sched_state_t;

  // Width of every delay counter (gap, settle, busy timeout)
  localparam int DLY_W = 16;

  // Delay-counter instance indices
  localparam int DLY_GAP    = 0;
  localparam int DLY_SETTLE = 1;
  localparam int DLY_TMO    = 2;
  localparam int DLY_NUM    = 3;

  // Command word layout is {rw, addr, data}; data sits at bit 0
  localparam int CMD_DATA_LSB = 0;

  function automatic int cmd_rw_bit(input int cmd_w);
    return cmd_w - 1;
  endfunction

  function automatic int cmd_addr_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/cmos_spi_cmd_scheduler_sched_delay_cnt.sv
// Reusable down-counter. Loading N gives o_last on the N-th enabled cycle,
// so a state that enables it while o_last is low lasts exactly N cycles.
module sched_delay_cnt
  import cmos_spi_cmd_scheduler_pkg::*;
#(
  parameter int W = DLY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt <= W'(1));

endmodule

// File: rtl/cmos_spi_cmd_scheduler.sv
// CMOS sensor configuration sequencer: pops commands from the FIFO, runs
// each through the SPI master, captures read-back data and, once a batch
// has drained, waits a settle time and emits one frame-start pulse.
module cmos_spi_cmd_scheduler
  import cmos_spi_cmd_scheduler_pkg::*;
#(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int CMD_W         = 1 + ADDR_W + DATA_W,
  parameter int GAP_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int BUSY_TIMEOUT  = 255,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_fifo_empty,
  output logic              cmd_fifo_rd_en,
  input  logic [CMD_W-1:0]  cmd_fifo_dout,
  output logic              spi_start,
  output logic [CMD_W-1:0]  spi_tx_word,
  input  logic              spi_busy,
  input  logic [DATA_W-1:0] spi_rx_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              nframe_output,
  output logic [CNT_W-1:0]  cmd_count,
  output logic              timeout_err
);

  localparam int RW_BIT = cmd_rw_bit(CMD_W);

  sched_state_t r_state;
  sched_state_t w_state_next;
  sched_state_t w_post_xact;

  logic              r_rw;
  logic              r_batch;
  logic [CMD_W-1:0]  r_tx_word;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [CNT_W-1:0]  r_cmd_count;
  logic              r_timeout_err;

  logic [DLY_NUM-1:0] w_dly_en;
  logic [DLY_NUM-1:0] w_dly_last;
  logic [DLY_W-1:0]   w_dly_val [DLY_NUM];
  logic               w_busy_timeout;
  logic               w_xact_done;

  assign w_dly_val[DLY_GAP]    = DLY_W'(GAP_CYCLES);
  assign w_dly_val[DLY_SETTLE] = DLY_W'(SETTLE_CYCLES);
  assign w_dly_val[DLY_TMO]    = DLY_W'(BUSY_TIMEOUT);

  // Each counter reloads whenever its state is inactive, so every entry
  // into GAP / SETTLE / WAIT_BUSY starts a fresh count.
  generate
    for (genvar gi = 0; gi < DLY_NUM; gi++) begin : g_dly
      sched_delay_cnt #(.W(DLY_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (!w_dly_en[gi]),
        .i_load_val (w_dly_val[gi]),
        .i_en       (w_dly_en[gi]),
        .o_last     (w_dly_last[gi])
      );
    end
  endgenerate

  assign w_busy_timeout = (r_state == ST_WAIT_BUSY) && !spi_busy && w_dly_last[DLY_TMO];
  assign w_xact_done    = (r_state == ST_WAIT_IDLE) && !spi_busy;

  // With a zero gap the post-transaction decision is taken immediately
  assign w_post_xact = (GAP_CYCLES != 0) ? ST_GAP :
                       (cmd_fifo_empty ? ST_SETTLE : ST_POP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (!cmd_fifo_empty) w_state_next = ST_POP;
                    else if (r_batch)    w_state_next = ST_SETTLE;
      ST_POP:       w_state_next = ST_LOAD;
      ST_LOAD:      w_state_next = ST_START;
      ST_START:     w_state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (spi_busy)                  w_state_next = ST_WAIT_IDLE;
                    else if (w_dly_last[DLY_TMO])  w_state_next = w_post_xact;
      ST_WAIT_IDLE: if (!spi_busy) w_state_next = w_post_xact;
      ST_GAP:       if (w_dly_last[DLY_GAP])
                      w_state_next = cmd_fifo_empty ? ST_SETTLE : ST_POP;
      ST_SETTLE:    if (!cmd_fifo_empty)               w_state_next = ST_POP;
                    else if (w_dly_last[DLY_SETTLE])   w_state_next = ST_FRAME;
      ST_FRAME:     w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded strobes and counter enables
  always_comb begin
    cmd_fifo_rd_en = 1'b0;
    spi_start      = 1'b0;
    nframe_output  = 1'b0;
    w_dly_en       = '0;
    case (r_state)
      ST_POP:       cmd_fifo_rd_en       = 1'b1;
      ST_START:     spi_start            = 1'b1;
      ST_WAIT_BUSY: w_dly_en[DLY_TMO]    = 1'b1;
      ST_GAP:       w_dly_en[DLY_GAP]    = 1'b1;
      ST_SETTLE:    w_dly_en[DLY_SETTLE] = 1'b1;
      ST_FRAME:     nframe_output        = 1'b1;
      default:      ;
    endcase
  end

  // Command word capture; held until the next LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_word <= '0;
      r_rw      <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_tx_word <= cmd_fifo_dout;
      r_rw      <= cmd_fifo_dout[RW_BIT];
    end
  end

  // Batch bookkeeping: count issued commands, clear on the frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_count <= '0;
      r_batch     <= 1'b0;
    end else if (r_state == ST_START) begin
      r_cmd_count <= r_cmd_count + 1'b1;
      r_batch     <= 1'b1;
    end else if (r_state == ST_FRAME) begin
      r_cmd_count <= '0;
      r_batch     <= 1'b0;
    end
  end

  // Read-back capture on the cycle busy is seen low; strobe follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_xact_done && r_rw;
      if (w_xact_done && r_rw) r_rd_data <= spi_rx_data;
    end
  end

  // Sticky busy-timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_timeout_err <= 1'b0;
    else if (w_busy_timeout) r_timeout_err <= 1'b1;
  end

  assign spi_tx_word = r_tx_word;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign cmd_count   = r_cmd_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cmos_spi_cmd_scheduler.sv
// Bench for cmos_spi_cmd_scheduler. Instance A uses default parameters;
// instance B uses a zero gap and short settle for the count-wrap test.
// FIFO and SPI master models run on the falling edge; the directed
// sequence drives stimulus 2 time units after each rising edge.
module tb_cmos_spi_cmd_scheduler;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 16;
  localparam int G      = 4;
  localparam int S      = 64;
  localparam int BT     = 255;
  localparam int CNT_W  = 8;
  localparam int SB     = 8;
  localparam int NB     = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- instance A signals and models ----------------
  logic              a_empty = 1'b1;
  logic              a_rd_en;
  logic [CMD_W-1:0]  a_dout  = '0;
  logic              a_start;
  logic [CMD_W-1:0]  a_tx;
  logic              a_busy  = 1'b0;
  logic [DATA_W-1:0] a_rx    = '0;
  logic [DATA_W-1:0] a_rdd;
  logic              a_rdv;
  logic              a_frame;
  logic [CNT_W-1:0]  a_cnt;
  logic              a_to;

  logic [CMD_W-1:0]  fifo_a[$];
  int                start_a[$], rden_a[$], fall_a[$], rdv_a[$], frame_a[$];
  logic [CMD_W-1:0]  txw_a[$];
  logic [DATA_W-1:0] rdd_a[$];
  int rise_at = -1, fall_at = -1, glitch_at = -1, to_cyc = -1, coincide = 0;
  int busy_dly = 2, busy_len = 16;
  bit no_busy = 1'b0;
  logic [DATA_W-1:0] rx_value = '0;

  cmos_spi_cmd_scheduler dut_a (
    .clk(clk), .rst(rst),
    .cmd_fifo_empty(a_empty), .cmd_fifo_rd_en(a_rd_en), .cmd_fifo_dout(a_dout),
    .spi_start(a_start), .spi_tx_word(a_tx), .spi_busy(a_busy), .spi_rx_data(a_rx),
    .rd_data(a_rdd), .rd_valid(a_rdv), .nframe_output(a_frame),
    .cmd_count(a_cnt), .timeout_err(a_to)
  );

  // FIFO + SPI master model and event log for instance A
  always @(negedge clk) begin
    if (rst) begin
      rise_at = -1; fall_at = -1; a_busy = 1'b0;
    end else begin
      if (a_rd_en) begin
        rden_a.push_back(cyc);
        if (fifo_a.size() > 0) a_dout = fifo_a.pop_front();
      end
      if (a_start) begin
        start_a.push_back(cyc);
        txw_a.push_back(a_tx);
        if (!no_busy) begin
          rise_at = cyc + busy_dly;
          fall_at = rise_at + busy_len;
        end
      end
      if (a_rdv) begin
        rdv_a.push_back(cyc);
        rdd_a.push_back(a_rdd);
        if (a_start) coincide++;
      end
      if (a_frame) frame_a.push_back(cyc);
      if (a_to && to_cyc < 0) to_cyc = cyc;
      a_busy = (cyc >= rise_at && cyc < fall_at) || (cyc == glitch_at);
      if (cyc == fall_at) begin
        a_rx = rx_value;
        fall_a.push_back(cyc);
      end else begin
        a_rx = 8'($urandom);
      end
    end
    a_empty = (fifo_a.size() == 0);
  end

  // ---------------- instance B (zero gap) ----------------
  logic              b_empty = 1'b1;
  logic              b_rd_en;
  logic [CMD_W-1:0]  b_dout  = '0;
  logic              b_start;
  logic [CMD_W-1:0]  b_tx;
  logic              b_busy  = 1'b0;
  logic [DATA_W-1:0] b_rx    = '0;
  logic [DATA_W-1:0] b_rdd;
  logic              b_rdv;
  logic              b_frame;
  logic [CNT_W-1:0]  b_cnt;
  logic              b_to;

  logic [CMD_W-1:0] fifo_b[$], expb[$], txw_b[$];
  int rise_b = -1, fall_b = -1, nframe_b = 0, nrdv_b = 0;
  bit wrap_b = 1'b0;
  logic [CNT_W-1:0] prev_cnt_b = '0;

  cmos_spi_cmd_scheduler #(.GAP_CYCLES(0), .SETTLE_CYCLES(SB)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_fifo_empty(b_empty), .cmd_fifo_rd_en(b_rd_en), .cmd_fifo_dout(b_dout),
    .spi_start(b_start), .spi_tx_word(b_tx), .spi_busy(b_busy), .spi_rx_data(b_rx),
    .rd_data(b_rdd), .rd_valid(b_rdv), .nframe_output(b_frame),
    .cmd_count(b_cnt), .timeout_err(b_to)
  );

  // FIFO + SPI master model for instance B: busy for two cycles after start
  always @(negedge clk) begin
    if (rst) begin
      rise_b = -1; fall_b = -1; b_busy = 1'b0;
    end else begin
      if (b_rd_en && fifo_b.size() > 0) b_dout = fifo_b.pop_front();
      if (b_start) begin
        txw_b.push_back(b_tx);
        rise_b = cyc + 1;
        fall_b = cyc + 3;
      end
      if (b_frame) nframe_b++;
      if (b_rdv) nrdv_b++;
      if (prev_cnt_b == 8'hFF && b_cnt == 8'h00) wrap_b = 1'b1;
      prev_cnt_b = b_cnt;
      b_busy = (cyc >= rise_b && cyc < fall_b);
      b_rx   = 8'($urandom);
    end
    b_empty = (fifo_b.size() == 0);
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_a();
    start_a.delete(); rden_a.delete(); fall_a.delete(); rdv_a.delete();
    frame_a.delete(); txw_a.delete(); rdd_a.delete();
    to_cyc = -1; coincide = 0; glitch_at = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   32'(a_rd_en), 0);
    check({tag, "_start"},   32'(a_start), 0);
    check({tag, "_tx"},      32'(a_tx),    0);
    check({tag, "_rd_data"}, 32'(a_rdd),   0);
    check({tag, "_rd_val"},  32'(a_rdv),   0);
    check({tag, "_frame"},   32'(a_frame), 0);
    check({tag, "_count"},   32'(a_cnt),   0);
    check({tag, "_tmo"},     32'(a_to),    0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [CMD_W-1:0] w[4];
    logic [DATA_W-1:0] r2;
    int t;

    tick(3);
    check_all_zero("reset");
    check("reset_b_count", 32'(b_cnt), 0);
    rst = 1'b0;
    tick(2);

    // Zero-gap build: 300 writes, count wraps, one frame at the end
    for (int i = 0; i < NB; i++) begin
      w[0] = {1'b0, 15'($urandom)};
      fifo_b.push_back(w[0]);
      expb.push_back(w[0]);
    end
    for (int k = 0; k < 4000 && txw_b.size() < NB; k++) tick(1);
    check("b_starts", txw_b.size(), NB);
    tick(2);
    check("b_count_wrapped", 32'(b_cnt), NB % 256);
    check("b_no_frame_yet", nframe_b, 0);
    for (int k = 0; k < 200 && nframe_b < 1; k++) tick(1);
    tick(100);
    check("b_frames", nframe_b, 1);
    check("b_count_after_frame", 32'(b_cnt), 0);
    check("b_wrap_seen", 32'(wrap_b), 1);
    check("b_no_rd_valid", nrdv_b, 0);
    for (int i = 0; i < NB && i < txw_b.size(); i++)
      check($sformatf("b_word%0d", i), 32'(txw_b[i]), 32'(expb[i]));

    // Single write: 0x85 does not fit the 7-bit address, so the write
    // form {0, 7'h05, 8'h3C} = 0x053C is used.
    clear_a();
    busy_dly = 2; busy_len = 16; rx_value = 8'h5A;
    fifo_a.push_back(16'h053C);
    t = cyc;
    for (int k = 0; k < 10 && start_a.size() < 1; k++) tick(1);
    check("t1_rd_en_cycle", (rden_a.size() > 0) ? rden_a[0] : -1, t + 1);
    check("t1_start_cycle", (start_a.size() > 0) ? start_a[0] : -1, t + 3);
    check("t1_tx_word", (txw_a.size() > 0) ? 32'(txw_a[0]) : 32'hFFFF_FFFF, 32'h053C);
    check("t1_count", 32'(a_cnt), 1);
    for (int k = 0; k < 200 && frame_a.size() < 1; k++) tick(1);
    check("t1_frame_cycle", (frame_a.size() > 0) ? frame_a[0] : -1,
          (fall_a.size() > 0) ? fall_a[0] + 1 + G + S : -2);
    tick(2);
    check("t1_count_cleared", 32'(a_cnt), 0);
    tick(100);
    check("t1_one_frame", frame_a.size(), 1);
    check("t1_no_rd_valid", rdv_a.size(), 0);

    // Write/read/write batch, glitches in GAP and SETTLE, refill at settle cycle 30
    clear_a();
    busy_dly = $urandom_range(1, 4); busy_len = $urandom_range(3, 20);
    rx_value = 8'hA5;
    r2 = 8'($urandom_range(1, 255));
    w[0] = {1'b0, 15'($urandom)};
    w[1] = {1'b1, 15'($urandom)};
    w[2] = {1'b0, 15'($urandom)};
    w[3] = {1'b1, 7'($urandom), 8'($urandom)};
    for (int i = 0; i < 3; i++) fifo_a.push_back(w[i]);
    for (int k = 0; k < 300 && fall_a.size() < 3; k++) tick(1);
    check("t2_three_done", fall_a.size(), 3);
    t = (fall_a.size() > 2) ? fall_a[2] : cyc;
    glitch_at = t + 2;
    while (cyc < t + G + 10) tick(1);
    glitch_at = t + G + 12;
    while (cyc < t + G + 30) tick(1);
    check("t2_no_frame_before_abort", frame_a.size(), 0);
    rx_value = r2;
    fifo_a.push_back(w[3]);
    for (int k = 0; k < 20 && start_a.size() < 4; k++) tick(1);
    check("t2_count4", 32'(a_cnt), 4);
    for (int k = 0; k < 100 && fall_a.size() < 4; k++) tick(1);
    glitch_at = ((fall_a.size() > 3) ? fall_a[3] : cyc) + G + 5;
    for (int k = 0; k < 300 && frame_a.size() < 1; k++) tick(1);
    tick(100);
    check("t2_starts", start_a.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_word%0d", i),
            (txw_a.size() > i) ? 32'(txw_a[i]) : 32'hFFFF_FFFF, 32'(w[i]));
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_gap%0d", i),
            (start_a.size() > i + 1 && fall_a.size() > i) ? 32'(start_a[i+1] - fall_a[i] >= G) : 0, 1);
    check("t2_rd_valid_count", rdv_a.size(), 2);
    check("t2_rd_data0", (rdd_a.size() > 0) ? 32'(rdd_a[0]) : 32'hFFFF_FFFF, 32'hA5);
    check("t2_rd_data1", (rdd_a.size() > 1) ? 32'(rdd_a[1]) : 32'hFFFF_FFFF, 32'(r2));
    check("t2_rd_valid_timing", (rdv_a.size() > 0) ? rdv_a[0] : -1,
          (fall_a.size() > 1) ? fall_a[1] + 1 : -2);
    check("t2_rdv_not_with_start", coincide, 0);
    check("t2_one_frame", frame_a.size(), 1);
    check("t2_frame_cycle", (frame_a.size() > 0) ? frame_a[0] : -1,
          (fall_a.size() > 3) ? fall_a[3] + 1 + G + S : -2);
    check("t2_count_cleared", 32'(a_cnt), 0);

    // Busy never rises: timeout, FSM carries on, frame still follows
    clear_a();
    no_busy = 1'b1;
    fifo_a.push_back({1'b0, 15'($urandom)});
    for (int k = 0; k < 400 && to_cyc < 0; k++) tick(1);
    check("t3_timeout_cycle", to_cyc, (start_a.size() > 0) ? start_a[0] + BT + 1 : -2);
    for (int k = 0; k < 200 && frame_a.size() < 1; k++) tick(1);
    tick(20);
    check("t3_frame_follows", frame_a.size(), 1);
    check("t3_timeout_sticky", 32'(a_to), 1);
    no_busy = 1'b0;

    // Reset while WAIT_IDLE: everything drops at once, no frame afterwards
    clear_a();
    busy_dly = 2; busy_len = 30;
    fifo_a.push_back({1'b1, 7'h2A, 8'hC3});
    for (int k = 0; k < 10 && start_a.size() < 1; k++) tick(1);
    t = (start_a.size() > 0) ? start_a[0] : cyc;
    while (cyc < t + 6) tick(1);
    check("t4_busy_before_rst", 32'(a_busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("t4_async");
    tick(3);
    rst = 1'b0;
    clear_a();
    tick(200);
    check("t4_no_frame", frame_a.size(), 0);
    check("t4_no_start", start_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
